// File: rtl/lsu_pkg.sv
// Shared encodings for the data-side load/store unit: funct3 codes, FSM
// state encoding, request record and default memory geometry.
package lsu_pkg;

   localparam int LSU_ADDR_W = 14;
   localparam int NUM_LANES  = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [2:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE   = 3'd0;
   localparam lsu_state_t ST_REQ    = 3'd1;
   localparam lsu_state_t ST_RESP   = 3'd2;
   localparam lsu_state_t ST_FENCE  = 3'd3;
   localparam lsu_state_t ST_FDRAIN = 3'd4;
   localparam lsu_state_t ST_DONE   = 3'd5;

   // Word address is kept outside the record so its width can follow ADDR_W.
   typedef struct packed {
      logic        store;
      logic [2:0]  funct3;
      logic [1:0]  addr_lo;
      logic [31:0] wdata;
   } lsu_req_t;

   // Access size in bytes-log2: 0 byte, 1 halfword, 2 word.
   function automatic logic [1:0] f3_size(input logic [2:0] f3);
      return f3[1:0];
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, alignment/legality checks and load extension.
// Purely combinational; fed either the incoming request or the latched one.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  ben,
   output logic [31:0] wdata_st,
   output logic [31:0] rdata_ext,
   output logic        misaligned,
   output logic        illegal
);

   logic [1:0]                  size;
   logic [NUM_LANES-1:0][7:0]   wd_lanes;
   logic [31:0]                 rd_sh;

   assign size = f3_size(funct3);

   // Each byte lane picks the store byte that lands on it after replication.
   for (genvar ln = 0; ln < NUM_LANES; ln++) begin : g_lane
      always_comb begin
         case (size)
            2'b00:   wd_lanes[ln] = wdata[7:0];
            2'b01:   wd_lanes[ln] = wdata[(ln % 2)*8 +: 8];
            default: wd_lanes[ln] = wdata[ln*8 +: 8];
         endcase
      end
   end
   assign wdata_st = wd_lanes;

   always_comb begin
      ben = 4'b1111;
      if (store) begin
         case (size)
            2'b00:   ben = 4'b0001 << addr_lo;
            2'b01:   ben = 4'b0011 << {addr_lo[1], 1'b0};
            default: ben = 4'b1111;
         endcase
      end
   end

   always_comb begin
      if (store) illegal = funct3[2] | (funct3[1:0] == 2'b11);
      else       illegal = (funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11);
   end

   assign misaligned = ((size == 2'b01) & addr_lo[0]) |
                       ((size == 2'b10) & (addr_lo != 2'b00));

   assign rd_sh = rdata >> {addr_lo, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    rdata_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
         F3_BU:   rdata_ext = {24'h0, rd_sh[7:0]};
         F3_H:    rdata_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
         F3_HU:   rdata_ext = {16'h0, rd_sh[15:0]};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/dm_lsu.sv
// Data-side load/store unit: one RV32I load, store or FENCE.I at a time
// toward main_mem, stalling execute through o_busy until completion.
module dm_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = LSU_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic              i_load,
   input  logic              i_store,
   input  logic              i_fence_i,
   input  logic [2:0]        i_funct3,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_fault,
   output logic [31:0]       o_rdata,
   output logic              o_dm_ren,
   output logic              o_dm_wen,
   output logic [3:0]        o_dm_ben,
   output logic [ADDR_W-1:0] o_dm_addr,
   output logic [31:0]       o_dm_wdata,
   input  logic [31:0]       i_dm_rdata,
   output logic              o_fence_i,
   input  logic              i_ready
);

   lsu_state_t        state;
   lsu_req_t          req_q, src;
   logic [ADDR_W-1:0] waddr_q;
   logic              fault_q, drain_first;
   logic [31:0]       rdata_q;
   logic              accept;

   logic [3:0]        ben;
   logic [31:0]       wdata_st, rdata_ext;
   logic              misaligned, illegal;

   // In IDLE the checker looks at the incoming request so a fault can be
   // reported on the very next cycle; afterwards it sees the latched copy.
   always_comb begin
      src = req_q;
      if (state == ST_IDLE) begin
         src.store   = i_store;
         src.funct3  = i_funct3;
         src.addr_lo = i_addr[1:0];
         src.wdata   = i_wdata;
      end
   end

   lsu_align u_align (
      .funct3     (src.funct3),
      .addr_lo    (src.addr_lo),
      .store      (src.store),
      .wdata      (src.wdata),
      .rdata      (i_dm_rdata),
      .ben        (ben),
      .wdata_st   (wdata_st),
      .rdata_ext  (rdata_ext),
      .misaligned (misaligned),
      .illegal    (illegal)
   );

   assign accept = i_valid & (i_load | i_store | i_fence_i);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         req_q       <= '0;
         waddr_q     <= '0;
         fault_q     <= 1'b0;
         drain_first <= 1'b0;
         rdata_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_q   <= src;
                  waddr_q <= i_addr[ADDR_W+1:2];
                  fault_q <= 1'b0;
                  if (i_fence_i) begin
                     state <= ST_FENCE;
                  end else if (misaligned | illegal) begin
                     fault_q <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (i_ready) state <= req_q.store ? ST_DONE : ST_RESP;
            end
            ST_RESP: begin
               rdata_q <= rdata_ext;
               state   <= ST_DONE;
            end
            ST_FENCE: begin
               drain_first <= 1'b1;
               state       <= ST_FDRAIN;
            end
            // main_mem may still show ready in the cycle right after fence_i.
            ST_FDRAIN: begin
               if (drain_first)  drain_first <= 1'b0;
               else if (i_ready) state       <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Everything below decodes the state register, so all outputs are glitch-
   // free registered values and fall to zero the edge after reset.
   assign o_busy     = (state != ST_IDLE);
   assign o_done     = (state == ST_DONE);
   assign o_fault    = o_done & fault_q;
   assign o_rdata    = rdata_q;
   assign o_fence_i  = (state == ST_FENCE);
   assign o_dm_ren   = (state == ST_REQ) & ~req_q.store;
   assign o_dm_wen   = (state == ST_REQ) &  req_q.store;
   assign o_dm_ben   = (state == ST_REQ) ? ben : 4'b0000;
   assign o_dm_addr  = (state == ST_REQ) ? waddr_q : '0;
   assign o_dm_wdata = o_dm_wen ? wdata_st : 32'h0;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: stimulus pushes expected completions, a
// monitor pops and checks them while a small main_mem model answers.
module tb_dm_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0, i_load = 1'b0, i_store = 1'b0, i_fence_i = 1'b0;
   logic [2:0]  i_funct3 = 3'b0;
   logic [31:0] i_addr = 32'h0, i_wdata = 32'h0;
   logic        o_busy, o_done, o_fault, o_dm_ren, o_dm_wen, o_fence_i;
   logic [31:0] o_rdata, o_dm_wdata;
   logic [3:0]  o_dm_ben;
   logic [13:0] o_dm_addr;
   logic [31:0] i_dm_rdata = 32'h0;
   logic        i_ready;

   dm_lsu #(.ADDR_W(14)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_load(i_load),
      .i_store(i_store), .i_fence_i(i_fence_i), .i_funct3(i_funct3),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
      .o_fault(o_fault), .o_rdata(o_rdata), .o_dm_ren(o_dm_ren),
      .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben), .o_dm_addr(o_dm_addr),
      .o_dm_wdata(o_dm_wdata), .i_dm_rdata(i_dm_rdata), .o_fence_i(o_fence_i),
      .i_ready(i_ready)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          exp_cyc;
      bit          fault;
      bit          chk_rd;
      logic [31:0] rd;
      bit          chk_mem;
      logic [3:0]  ben;
      logic [13:0] addr;
      bit          chk_wd;
      logic [31:0] wd;
      int          acc;
      int          fences;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   ntest = 0, nfail = 0;

   // main_mem model controls
   logic [31:0] rd_word = 32'h0;
   int          stall_set = 0;
   int          fence_drop = 0;
   int          stall_seen = 0;
   int          drain_cnt = 0;
   bit          rst_chk = 1'b1;

   always @(posedge i_clk) cyc <= cyc + 1;

   assign i_ready = (drain_cnt == 0) &&
                    !((o_dm_ren || o_dm_wen) && (stall_seen < stall_set));

   always @(posedge i_clk) begin
      if (o_dm_ren && i_ready) i_dm_rdata <= rd_word;
      if (o_dm_ren || o_dm_wen) begin
         if (!i_ready) stall_seen <= stall_seen + 1;
      end else begin
         stall_seen <= 0;
      end
      if (o_fence_i)          drain_cnt <= fence_drop;
      else if (drain_cnt > 0) drain_cnt <= drain_cnt - 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   int acc_cyc = 0, fence_cyc = 0;
   always begin
      @(posedge i_clk);
      #1;
      if (rst_chk) begin
         chk("rst_busy",  {31'b0, o_busy}, 32'h0);
         chk("rst_done",  {31'b0, o_done}, 32'h0);
         chk("rst_rdata", o_rdata, 32'h0);
         chk("rst_req",   {29'b0, o_dm_ren, o_dm_wen, o_fence_i}, 32'h0);
         chk("rst_bus",   {14'b0, o_dm_ben, o_dm_addr}, 32'h0);
      end
      if (i_rst) begin
         acc_cyc   = 0;
         fence_cyc = 0;
      end else begin
         if (o_dm_ren && o_dm_wen) chk("ren_wen_excl", 32'h1, 32'h0);
         if (o_fence_i) fence_cyc++;
         if (o_dm_ren || o_dm_wen) begin
            acc_cyc++;
            if (sbq.size() != 0 && sbq[0].chk_mem) begin
               chk("dm_ben",  {28'b0, o_dm_ben}, {28'b0, sbq[0].ben});
               chk("dm_addr", {18'b0, o_dm_addr}, {18'b0, sbq[0].addr});
               if (sbq[0].chk_wd) chk("dm_wdata", o_dm_wdata, sbq[0].wd);
            end
         end
         if (o_done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'h1, 32'h0);
            end else begin
               chk("done_cycle", cyc, sbq[0].exp_cyc);
               chk("fault", {31'b0, o_fault}, {31'b0, sbq[0].fault});
               if (sbq[0].chk_rd) chk("rdata", o_rdata, sbq[0].rd);
               chk("mem_cycles", acc_cyc, sbq[0].acc);
               chk("fence_pulses", fence_cyc, sbq[0].fences);
               void'(sbq.pop_front());
            end
            acc_cyc   = 0;
            fence_cyc = 0;
         end else if (sbq.size() != 0 && cyc > sbq[0].exp_cyc + 20) begin
            chk("done_timeout", cyc, sbq[0].exp_cyc);
            void'(sbq.pop_front());
            acc_cyc   = 0;
            fence_cyc = 0;
         end
      end
   end

   task automatic issue(input bit ld, input bit st, input bit fc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        input exp_t e);
      @(negedge i_clk);
      e.exp_cyc = cyc + 1 + lat;
      sbq.push_back(e);
      i_valid = 1'b1; i_load = ld; i_store = st; i_fence_i = fc;
      i_funct3 = f3; i_addr = a; i_wdata = wd;
      @(negedge i_clk);
      i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_fence_i = 1'b0;
      for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge i_clk);
   endtask

   function automatic exp_t blank();
      exp_t e;
      e.exp_cyc = 0; e.fault = 1'b0; e.chk_rd = 1'b0; e.rd = 32'h0;
      e.chk_mem = 1'b0; e.ben = 4'h0; e.addr = 14'h0; e.chk_wd = 1'b0;
      e.wd = 32'h0; e.acc = 0; e.fences = 0;
      return e;
   endfunction

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] xben, input logic [13:0] xaddr,
                           input logic [31:0] xwd, input int stall);
      exp_t e = blank();
      e.chk_mem = 1'b1; e.ben = xben; e.addr = xaddr; e.chk_wd = 1'b1; e.wd = xwd;
      e.acc = 1 + stall;
      stall_set = stall;
      issue(1'b0, 1'b1, 1'b0, f3, a, wd, 1 + stall, e);
      stall_set = 0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [13:0] xaddr,
                          input logic [31:0] word, input logic [31:0] xrd);
      exp_t e = blank();
      e.chk_mem = 1'b1; e.ben = 4'hF; e.addr = xaddr; e.chk_rd = 1'b1; e.rd = xrd;
      e.acc = 1;
      rd_word = word;
      issue(1'b1, 1'b0, 1'b0, f3, a, 32'h0, 2, e);
   endtask

   task automatic do_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
      exp_t e = blank();
      e.fault = 1'b1;
      issue(!st, st, 1'b0, f3, a, 32'h1234_5678, 0, e);
   endtask

   task automatic do_fence(input int drop, input int lat);
      exp_t e = blank();
      e.fences = 1;
      fence_drop = drop;
      issue(1'b1, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0, lat, e);
      fence_drop = 0;
   endtask

   initial begin
      // Reset state, checked over several edges.
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      rst_chk = 1'b0;
      @(negedge i_clk);

      do_store(3'b000, 32'h0000_0102, 32'h0000_00A5, 4'b0100, 14'h040, 32'hA5A5_A5A5, 0);
      do_load (3'b000, 32'h0000_0103, 14'h040, 32'h8012_3456, 32'hFFFF_FF80);
      do_load (3'b100, 32'h0000_0103, 14'h040, 32'h8012_3456, 32'h0000_0080);
      do_load (3'b001, 32'h0000_0102, 14'h040, 32'h8001_1234, 32'hFFFF_8001);
      do_fault(1'b0, 3'b010, 32'h0000_0202);
      do_fault(1'b0, 3'b011, 32'h0000_0200);
      do_store(3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 14'h004, 32'hDEAD_BEEF, 3);
      do_fence(5, 7);
      do_store(3'b001, 32'h0000_0106, 32'h1234_ABCD, 4'b1100, 14'h041, 32'hABCD_ABCD, 0);
      do_load (3'b101, 32'h0000_0100, 14'h040, 32'h1234_F00D, 32'h0000_F00D);
      do_load (3'b010, 32'h0001_0008, 14'h002, 32'hCAFE_BABE, 32'hCAFE_BABE);
      do_fault(1'b1, 3'b001, 32'h0000_0101);
      do_fault(1'b1, 3'b100, 32'h0000_0100);
      do_fault(1'b0, 3'b110, 32'h0000_0100);
      do_fence(0, 3);
      do_store(3'b000, 32'h0000_0003, 32'hFFFF_FF3C, 4'b1000, 14'h000, 32'h3C3C_3C3C, 1);

      // Reset while a load sits in RESP: no completion may follow.
      rd_word = 32'h7777_7777;
      @(negedge i_clk);
      i_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0040;
      @(negedge i_clk);
      i_valid = 1'b0; i_load = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      rst_chk = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      rst_chk = 1'b0;
      repeat (5) @(negedge i_clk);

      // Still functional after the abort.
      do_load(3'b000, 32'h0000_0001, 14'h000, 32'h0000_7F00, 32'h0000_007F);

      repeat (3) @(negedge i_clk);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
